guess_sequencer: RTL

GUESS_SEQUENCER -- requirements
Module: guess_sequencer

---
 rtl/guess_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/guess_sequencer.sv
// guess_sequencer
// Game sequencer for a handwritten 4-digit "Bulls and Cows" style guessing game.
// The player selects one of four display slots, draws a digit that an external
// classifier recognises, and presses Enter. A legal guess has four distinct
// digits 0-9. It is scored against the latched secret over four cycles,
// one slot per cycle, to give A (right digit, right place) and B
// (right digit, wrong place) counts.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   secret          - secret number, slot k = secret[4k+3:4k]
//   secret_valid    - level, secret is stable and legal (sampled in IDLE only)
//   digit_pulse     - one-cycle slot-select pulses, bit k selects slot k
//   enter_pulse     - one-cycle Enter button pulse
//   clear_pulse     - one-cycle Clear button pulse
//   recog_valid     - one-cycle pulse, recog_digit is valid
//   recog_digit     - digit from the handwriting classifier
//   signal          - displayed guess, 4'hF in a slot means blank
//   active_digits   - one-hot highlight of the selected slot, 0 = none
//   border_disable  - suppresses slot borders while scoring / after a win
//   canvas_clear    - one-cycle pulse wiping the drawing canvas
//   entry_error     - one-cycle pulse, Enter rejected
//   result_valid    - one-cycle pulse, a_cnt / b_cnt updated
//   a_cnt, b_cnt    - score of the last guess
//   guess_cnt       - number of scored guesses, saturating at 15
//   win             - level, last guess scored 4A
module guess_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] secret,
  input  logic        secret_valid,
  input  logic [3:0]  digit_pulse,
  input  logic        enter_pulse,
  input  logic        clear_pulse,
  input  logic        recog_valid,
  input  logic [3:0]  recog_digit,
  output logic [15:0] signal,
  output logic [3:0]  active_digits,
  output logic        border_disable,
  output logic        canvas_clear,
  output logic        entry_error,
  output logic        result_valid,
  output logic [2:0]  a_cnt,
  output logic [2:0]  b_cnt,
  output logic [3:0]  guess_cnt,
  output logic        win
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DRAW,
    CHECK,
    RESULT,
    WIN
  } state_t;

  state_t      state;
  logic [15:0] secret_q;
  logic [1:0]  sel;
  logic [1:0]  idx;

  logic [3:0]  digit_onehot;
  logic [1:0]  digit_slot;
  logic [3:0]  guess_slot;
  logic [3:0]  secret_slot;
  logic        in_secret;
  logic        recog_ok;
  logic        guess_ok;

  // A guess is legal when every slot holds 0-9 and no two slots repeat.
  function automatic logic guess_legal(input logic [15:0] g);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (g[4*i +: 4] > 4'd9) ok = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (g[4*i +: 4] == g[4*j +: 4]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Isolate the lowest set bit so simultaneous slot presses pick the lowest slot.
  assign digit_onehot = digit_pulse & (~digit_pulse + 4'd1);

  // Encode that one-hot slot as an index used to address the display nibble.
  always_comb begin
    digit_slot = 2'd0;
    if (digit_pulse[0])      digit_slot = 2'd0;
    else if (digit_pulse[1]) digit_slot = 2'd1;
    else if (digit_pulse[2]) digit_slot = 2'd2;
    else if (digit_pulse[3]) digit_slot = 2'd3;
  end

  // Slot under test during scoring, and whether that guess digit occurs anywhere
  // in the secret (only consulted when it is not an exact positional match).
  assign guess_slot  = signal[{idx, 2'b00} +: 4];
  assign secret_slot = secret_q[{idx, 2'b00} +: 4];
  assign in_secret   = (guess_slot == secret_q[3:0])  || (guess_slot == secret_q[7:4]) ||
                       (guess_slot == secret_q[11:8]) || (guess_slot == secret_q[15:12]);
  assign recog_ok    = recog_valid && (recog_digit <= 4'd9);
  assign guess_ok    = guess_legal(signal);

  // Main game FSM. All outputs are registered here. The one-cycle pulses
  // default low and are raised only on the edge that starts their cycle.
  // In SELECT/DRAW the if/else chain gives clear > enter > digit > recog,
  // so lower-priority inputs arriving in the same cycle are simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      signal         <= 16'hFFFF;
      active_digits  <= 4'd0;
      a_cnt          <= 3'd0;
      b_cnt          <= 3'd0;
      guess_cnt      <= 4'd0;
      idx            <= 2'd0;
      sel            <= 2'd0;
      secret_q       <= 16'd0;
      win            <= 1'b0;
      border_disable <= 1'b0;
      canvas_clear   <= 1'b0;
      entry_error    <= 1'b0;
      result_valid   <= 1'b0;
    end else begin
      canvas_clear <= 1'b0;
      entry_error  <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (secret_valid) begin
            secret_q  <= secret;
            guess_cnt <= 4'd0;
            a_cnt     <= 3'd0;
            b_cnt     <= 3'd0;
            state     <= SELECT;
          end
        end
        SELECT, DRAW: begin
          if (clear_pulse) begin
            canvas_clear <= 1'b1;
            if (state == SELECT) signal <= 16'hFFFF;
            else                 signal[{sel, 2'b00} +: 4] <= 4'hF;
          end else if (enter_pulse) begin
            if (guess_ok) begin
              active_digits  <= 4'd0;
              canvas_clear   <= 1'b1;
              a_cnt          <= 3'd0;
              b_cnt          <= 3'd0;
              idx            <= 2'd0;
              border_disable <= 1'b1;
              state          <= CHECK;
            end else begin
              entry_error <= 1'b1;
            end
          end else if (|digit_pulse) begin
            active_digits <= digit_onehot;
            sel           <= digit_slot;
            state         <= DRAW;
          end else if (state == DRAW && recog_ok) begin
            signal[{sel, 2'b00} +: 4] <= recog_digit;
          end
        end
        CHECK: begin
          if (guess_slot == secret_slot) a_cnt <= a_cnt + 3'd1;
          else if (in_secret)            b_cnt <= b_cnt + 3'd1;
          idx <= idx + 2'd1;
          // The score is complete on this edge, so RESULT presents it together
          // with result_valid and the updated guess count.
          if (idx == 2'd3) begin
            state        <= RESULT;
            result_valid <= 1'b1;
            if (guess_cnt != 4'd15) guess_cnt <= guess_cnt + 4'd1;
          end
        end
        RESULT: begin
          if (a_cnt == 3'd4) begin
            win   <= 1'b1;
            state <= WIN;
          end else begin
            signal         <= 16'hFFFF;
            border_disable <= 1'b0;
            state          <= SELECT;
          end
        end
        WIN: begin
          if (clear_pulse) begin
            win            <= 1'b0;
            signal         <= 16'hFFFF;
            canvas_clear   <= 1'b1;
            border_disable <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
